// File: rtl/uart_periph_ctrl.sv
// Memory-mapped UART controller: baud generator, RX capture, TX request sequencing,
// UART_CON status/irq flags and a level interrupt to the CPU.
module uart_periph_ctrl #(
    parameter int unsigned BAUD_DIV = 652,
    parameter logic [31:0] BASE_TXD = 32'h4000_0018,
    parameter logic [31:0] BASE_RXD = 32'h4000_001C,
    parameter logic [31:0] BASE_CON = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        baud_clk,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        irq
);

    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    logic [CNT_W-1:0] baud_cnt;
    logic             rx_s1, rx_s2, rx_s3;
    logic             tx_s1, tx_s2;
    logic             rx_evt;
    logic [7:0]       rxd;
    logic             con_tie, con_rie, con_tx_done, con_rx_done, con_rx_ovr;
    logic             con_rd, con_wr, txd_wr;
    tx_state_t        state, state_next;
    logic             tx_load, tx_done_set, tx_en_next;
    logic             tx_busy;
    logic             unused_wdata;

    assign con_rd  = bus_rd && (bus_addr == BASE_CON);
    assign con_wr  = bus_wr && (bus_addr == BASE_CON);
    assign txd_wr  = bus_wr && (bus_addr == BASE_TXD);
    assign rx_evt  = rx_s2 & ~rx_s3;
    assign tx_busy = (state != TX_IDLE);
    assign unused_wdata = ^bus_wdata[31:8];

    // Half-period counter; baud_clk toggles on every wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            baud_clk <= 1'b0;
        end else if (baud_cnt == CNT_MAX) begin
            baud_cnt <= '0;
            baud_clk <= ~baud_clk;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchronizers; third rx flop forms the rising-edge detector.
    // tx sync resets to idle so an early TXD write cannot see a false busy phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b0;
            rx_s2 <= 1'b0;
            rx_s3 <= 1'b0;
            tx_s1 <= 1'b1;
            tx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_status;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            tx_s1 <= tx_status;
            tx_s2 <= tx_s1;
        end
    end

    // RX capture, CON flags (set beats clear-on-read) and registered irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd         <= 8'h00;
            con_tie     <= 1'b0;
            con_rie     <= 1'b0;
            con_tx_done <= 1'b0;
            con_rx_done <= 1'b0;
            con_rx_ovr  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (con_wr) begin
                con_tie <= bus_wdata[0];
                con_rie <= bus_wdata[1];
            end
            if (rx_evt) begin
                rxd         <= rx_data;
                con_rx_done <= 1'b1;
            end else if (con_rd) begin
                con_rx_done <= 1'b0;
            end
            if (rx_evt && con_rx_done) begin
                con_rx_ovr <= 1'b1;
            end else if (con_rd) begin
                con_rx_ovr <= 1'b0;
            end
            if (tx_done_set) begin
                con_tx_done <= 1'b1;
            end else if (con_rd) begin
                con_tx_done <= 1'b0;
            end
            irq <= (con_tie & con_tx_done) | (con_rie & con_rx_done);
        end
    end

    // TX state register with latched byte and registered request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            tx_data <= 8'h00;
            tx_en   <= 1'b0;
        end else begin
            state <= state_next;
            tx_en <= tx_en_next;
            if (tx_load) begin
                tx_data <= bus_wdata[7:0];
            end
        end
    end

    // TX next-state: request until the transmitter goes busy, then wait for idle
    always_comb begin
        state_next  = state;
        tx_load     = 1'b0;
        tx_done_set = 1'b0;
        case (state)
            TX_IDLE: begin
                if (txd_wr) begin
                    tx_load    = 1'b1;
                    state_next = TX_REQ;
                end
            end
            TX_REQ: begin
                if (!tx_s2) begin
                    state_next = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_s2) begin
                    tx_done_set = 1'b1;
                    state_next  = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
        tx_en_next = (state_next == TX_REQ);
    end

    // Read mux; values are pre-update so a simultaneous write is not visible
    always_comb begin
        bus_rdata = 32'h0;
        if (bus_rd) begin
            if (bus_addr == BASE_RXD) begin
                bus_rdata = {24'h0, rxd};
            end else if (bus_addr == BASE_CON) begin
                bus_rdata = {26'h0, con_rx_ovr, tx_busy, con_rx_done,
                             con_tx_done, con_rie, con_tie};
            end
        end
    end

endmodule

// File: tb/tb_uart_periph_ctrl.sv
// Self-checking bench for uart_periph_ctrl: vector table, directed corner cases,
// and randomized RX/CON traffic against a transaction-level model.
module tb_uart_periph_ctrl;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        baud_clk;
    logic [7:0]  rx_data;
    logic        rx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Transaction-level model of the register file
    logic       m_tie, m_rie, m_txdone, m_rxdone, m_ovr;
    logic [7:0] m_rxd;

    uart_periph_ctrl #(.BAUD_DIV(8)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .baud_clk(baud_clk), .rx_data(rx_data), .rx_status(rx_status),
        .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = wdata;
        @(negedge clk);
        rdata = bus_rdata;
        @(posedge clk);
        #1;
        bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
        bus_cycle(1'b1, 1'b0, addr, 32'h0, rdata);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_cycle(1'b0, 1'b1, addr, wdata, dummy);
    endtask

    function automatic logic [31:0] model_con(input logic busy);
        return {26'h0, m_ovr, busy, m_rxdone, m_txdone, m_rie, m_tie};
    endfunction

    function automatic logic model_irq();
        return (m_tie & m_txdone) | (m_rie & m_rxdone);
    endfunction

    task automatic model_reset();
        m_tie = 0; m_rie = 0; m_txdone = 0; m_rxdone = 0; m_ovr = 0; m_rxd = 8'h00;
    endtask

    // One receiver done pulse, one baud period wide, then settle through the sync
    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b; rx_status = 1'b1;
        tick(8);
        rx_status = 1'b0;
        tick(5);
        if (m_rxdone) m_ovr = 1'b1;
        m_rxdone = 1'b1;
        m_rxd    = b;
    endtask

    task automatic model_con_read(input string name);
        logic [31:0] r;
        bus_read(A_CON, r);
        chk(name, r, model_con(1'b0));
        m_txdone = 0; m_rxdone = 0; m_ovr = 0;
    endtask

    initial begin
        logic [31:0] r;
        int toggles, highs, seen, waited;
        logic prev;

        reset = 1'b1; bus_addr = 0; bus_rd = 0; bus_wr = 0; bus_wdata = 0;
        rx_data = 0; rx_status = 0; tx_status = 1'b1;
        model_reset();

        vecs[0] = '{1'b1, 1'b0, A_CON, 32'h0,          1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, A_RXD, 32'h0,          1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, A_CON, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, A_CON, 32'h0,          1'b1, 32'h3};
        vecs[4] = '{1'b0, 1'b1, A_BAD, 32'h0,          1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, A_CON, 32'h0,          1'b1, 32'h3};
        vecs[6] = '{1'b1, 1'b0, A_BAD, 32'h0,          1'b1, 32'h0};
        vecs[7] = '{1'b1, 1'b1, A_CON, 32'h1,          1'b1, 32'h3};
        vecs[8] = '{1'b1, 1'b0, A_CON, 32'h0,          1'b1, 32'h1};
        vecs[9] = '{1'b0, 1'b1, A_CON, 32'h0,          1'b0, 32'h0};

        tick(3);
        chk("reset_baud_clk", {31'h0, baud_clk}, 32'h0);
        chk("reset_tx_en",    {31'h0, tx_en},    32'h0);
        chk("reset_tx_data",  {24'h0, tx_data},  32'h0);
        chk("reset_irq",      {31'h0, irq},      32'h0);
        reset = 1'b0;
        tick(1);

        // Baud generator: 65 samples -> 64 transitions windows, 16 toggles, 32 high
        toggles = 0; highs = 0;
        @(negedge clk); prev = baud_clk; highs += int'(baud_clk);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (baud_clk != prev) toggles++;
            if (i < 63) highs += int'(baud_clk);
            prev = baud_clk;
        end
        chk("baud_toggles", 32'(toggles), 32'd16);
        chk("baud_high",    32'(highs),   32'd32);
        tick(1);

        // Register-access vectors
        for (int i = 0; i < 10; i++) begin
            bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, r);
            if (vecs[i].chk) chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        model_reset();

        // Single RX byte, clear-on-read
        rx_pulse(8'hA5);
        bus_read(A_RXD, r); chk("rxd_a5", r, 32'h0000_00A5);
        bus_read(A_CON, r); chk("con_rx_done", r, 32'h8);
        bus_read(A_CON, r); chk("con_cleared", r, 32'h0);
        m_rxdone = 0;

        // Overrun
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(A_RXD, r); chk("rxd_ovr", r, 32'h22);
        bus_read(A_CON, r); chk("con_ovr", r, 32'h28);
        m_rxdone = 0; m_ovr = 0;

        // RX event coinciding with a CON read: set wins, exactly one read sees it
        seen = 0;
        rx_data = 8'h3C; rx_status = 1'b1;
        bus_rd = 1'b1; bus_addr = A_CON;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_rdata[3]) seen++;
            @(posedge clk); #1;
            if (i == 7) rx_status = 1'b0;
        end
        bus_rd = 1'b0; bus_addr = 0;
        chk("rx_set_wins", 32'(seen), 32'd1);
        bus_read(A_CON, r); chk("con_after_race", r, 32'h0);

        // Transmit sequence
        bus_write(A_CON, 32'h3); m_tie = 1; m_rie = 1;
        bus_write(A_TXD, 32'h155);
        chk("tx_en_req",  {31'h0, tx_en}, 32'h1);
        chk("tx_data_55", {24'h0, tx_data}, 32'h55);
        tick(3);
        chk("tx_en_held", {31'h0, tx_en}, 32'h1);
        tx_status = 1'b0;
        waited = 0;
        while (tx_en && waited < 20) begin tick(1); waited++; end
        chk("tx_en_drop", {31'h0, tx_en}, 32'h0);
        bus_read(A_CON, r); chk("con_busy", r, 32'h13);
        bus_write(A_TXD, 32'h1AA);
        chk("tx_drop_data", {24'h0, tx_data}, 32'h55);
        tick(90);
        chk("tx_en_busy", {31'h0, tx_en}, 32'h0);
        tx_status = 1'b1;
        tick(5);
        m_txdone = 1;
        chk("irq_tx", {31'h0, irq}, {31'h0, model_irq()});
        model_con_read("con_tx_done");
        tick(2);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Randomized RX/CON traffic against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: rx_pulse(8'($urandom()));
                1: model_con_read("rnd_con");
                2: begin bus_read(A_RXD, r); chk("rnd_rxd", r, {24'h0, m_rxd}); end
                3: begin
                    r = $urandom();
                    bus_write(A_CON, r);
                    m_tie = r[0]; m_rie = r[1];
                end
                default: begin bus_read(A_BAD, r); chk("rnd_unmapped", r, 32'h0); end
            endcase
            tick(2);
            chk("rnd_irq", {31'h0, irq}, {31'h0, model_irq()});
        end

        // Reset during TX_REQ with an rx flag pending
        bus_write(A_CON, 32'h3);
        rx_pulse(8'h5A);
        bus_write(A_TXD, 32'h0C3);
        tick(2);
        chk("pre_rst_irq",   {31'h0, irq},   32'h1);
        chk("pre_rst_tx_en", {31'h0, tx_en}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_tx_en",   {31'h0, tx_en},    32'h0);
        chk("rst_irq",     {31'h0, irq},      32'h0);
        chk("rst_tx_data", {24'h0, tx_data},  32'h0);
        chk("rst_baud",    {31'h0, baud_clk}, 32'h0);
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(10);
        model_con_read("post_rst_con");
        bus_read(A_RXD, r); chk("post_rst_rxd", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
